// File: rtl/prog_loader.sv
// Two-wire serial programming port for program memory: shifts in commands and
// data frames, writes or reads instruction words, and holds the core in reset.
module prog_loader #(
    parameter int INST_WIDTH = 12,
    parameter int ADDR_WIDTH = 9,
    parameter int CMD_BITS   = 6,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pgmEn,
    input  logic                  pgmClk,
    input  logic                  pgmDataIn,
    output logic                  pgmDataOut,
    output logic                  pgmDataOe,
    output logic                  cpuHold,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [INST_WIDTH-1:0] memWData,
    input  logic [INST_WIDTH-1:0] memRData,
    output logic                  busy
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_BITS - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] FRAME_END  = CW'(FRAME_BITS);

    localparam logic [3:0] OP_LOAD = 4'h2;
    localparam logic [3:0] OP_READ = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_PROG = 4'h8;

    typedef enum logic [2:0] {IDLE, CMD, LOAD, READ, WRITE} state_t;

    state_t state, nextState;

    logic [1:0]            enSync, clkSync, dataSync;
    logic                  enPrev, clkPrev;
    logic                  enLvl, enRise, clkRise, clkFall, dataBit;
    logic [CW-1:0]         bitCnt;
    logic [CMD_BITS-2:0]   cmdSh;
    logic [FRAME_BITS-3:0] frameSh;
    logic [FRAME_BITS-1:0] rdSh;
    logic [ADDR_WIDTH-1:0] addr;
    logic [INST_WIDTH-1:0] dataLatch;
    logic [3:0]            opcode;
    logic                  cmdDone, loadDone, readDone;

    assign enLvl   = enSync[1];
    assign enRise  = enSync[1] & ~enPrev;
    assign clkRise = clkSync[1] & ~clkPrev;
    assign clkFall = ~clkSync[1] & clkPrev;
    assign dataBit = dataSync[1];

    // The first CMD_BITS-1 bits sit in cmdSh; the last (don't-care) bit is never stored.
    assign opcode   = cmdSh[3:0];
    assign cmdDone  = (state == CMD)  && clkRise && (bitCnt == CMD_LAST)   && enLvl;
    assign loadDone = (state == LOAD) && clkRise && (bitCnt == FRAME_LAST) && enLvl;
    assign readDone = (state == READ) && clkFall && (bitCnt == FRAME_END);

    assign memAddr  = addr;
    assign memWData = dataLatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enSync   <= '0;
            clkSync  <= '0;
            dataSync <= '0;
            enPrev   <= 1'b0;
            clkPrev  <= 1'b0;
        end else begin
            enSync   <= {enSync[0], pgmEn};
            clkSync  <= {clkSync[0], pgmClk};
            dataSync <= {dataSync[0], pgmDataIn};
            enPrev   <= enSync[1];
            clkPrev  <= clkSync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (state != IDLE && !enLvl) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:  if (enRise) nextState = CMD;
                CMD: begin
                    if (cmdDone) begin
                        case (opcode)
                            OP_LOAD: nextState = LOAD;
                            OP_READ: nextState = READ;
                            OP_PROG: nextState = WRITE;
                            default: nextState = CMD;
                        endcase
                    end
                end
                LOAD:  if (loadDone) nextState = CMD;
                READ:  if (readDone) nextState = CMD;
                WRITE: nextState = CMD;
                default: nextState = IDLE;
            endcase
        end
    end

    // Write strobe is gated by the enable level so an abort in the same cycle never writes.
    always_comb begin
        memWe     = (state == WRITE) && enLvl;
        busy      = (state == WRITE) && enLvl;
        pgmDataOe = (state == READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt     <= '0;
            cmdSh      <= '0;
            frameSh    <= '0;
            rdSh       <= '0;
            addr       <= '0;
            dataLatch  <= '0;
            pgmDataOut <= 1'b0;
            cpuHold    <= 1'b0;
        end else begin
            // Hold is released one clock after the FSM has settled in IDLE.
            cpuHold <= (state == IDLE) ? enRise : 1'b1;

            if (state != nextState || cmdDone) begin
                bitCnt <= '0;
            end else if (clkRise && (state == CMD || state == LOAD ||
                                     (state == READ && bitCnt != FRAME_END))) begin
                bitCnt <= bitCnt + 1'b1;
            end

            if (state == IDLE && enRise) begin
                addr <= '0;
            end else if (cmdDone && opcode == OP_INC) begin
                addr <= addr + 1'b1;
            end

            if (state == CMD && clkRise) begin
                cmdSh <= {dataBit, cmdSh[CMD_BITS-2:1]};
            end

            // frameSh drops frame bit 0, so after 15 bits it holds bits 14:1.
            if (state == LOAD && clkRise) begin
                frameSh <= {dataBit, frameSh[FRAME_BITS-3:1]};
            end
            if (loadDone) begin
                dataLatch <= frameSh[INST_WIDTH-1:0];
            end

            if (cmdDone && opcode == OP_READ) begin
                rdSh <= {{(FRAME_BITS-INST_WIDTH-1){1'b0}}, memRData, 1'b0};
            end

            if (state == READ) begin
                if (clkRise && bitCnt != FRAME_END) begin
                    pgmDataOut <= rdSh[0];
                    rdSh       <= {1'b0, rdSh[FRAME_BITS-1:1]};
                end
            end else begin
                pgmDataOut <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: host-level driver, transaction model of address,
// latch and memory contents, and a write monitor fed by an expected queue.
module tb_prog_loader;

    localparam int IW = 12;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n, pgmEn, pgmClk, pgmDataIn;
    logic          pgmDataOut, pgmDataOe, cpuHold, memWe, busy;
    logic [AW-1:0] memAddr;
    logic [IW-1:0] memWData, memRData;

    logic [IW-1:0] physMem [0:511];
    logic [IW-1:0] refMem  [0:511];
    logic [AW-1:0] mAddr;
    logic [IW-1:0] mLatch;
    logic [AW+IW-1:0] expQ[$];
    logic          runDone = 1'b0;

    int checks = 0;
    int errors = 0;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .pgmEn(pgmEn), .pgmClk(pgmClk),
        .pgmDataIn(pgmDataIn), .pgmDataOut(pgmDataOut), .pgmDataOe(pgmDataOe),
        .cpuHold(cpuHold), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .busy(busy)
    );

    always #5 clk = ~clk;

    assign memRData = physMem[memAddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n && memWe) begin
            check("busyWithWe", busy, 1);
            check("holdDuringWe", cpuHold, 1);
            if (expQ.size() == 0) begin
                check("unexpectedWe", memWe, 0);
            end else begin
                check("writeAddrData", {memAddr, memWData}, expQ.pop_front());
            end
            physMem[memAddr] = memWData;
        end else if (rst_n && busy) begin
            check("busyWithoutWe", busy, 0);
        end
    end

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        pgmDataIn = b;
        waitClks(4);
        pgmClk = 1'b1;
        waitClks(4);
        pgmClk = 1'b0;
    endtask

    task automatic sendCmd(input logic [5:0] c);
        for (int i = 0; i < 6; i++) sendBit(c[i]);
    endtask

    function automatic logic [5:0] mkCmd(input logic [3:0] op);
        logic [1:0] hi;
        hi = 2'($urandom_range(0, 3));
        return {hi, op};
    endfunction

    task automatic startSession();
        pgmEn = 1'b1;
        waitClks(6);
        mAddr = '0;
        check("holdInSession", cpuHold, 1);
        check("addrAtStart", memAddr, mAddr);
    endtask

    task automatic endSession();
        pgmEn = 1'b0;
        waitClks(6);
        check("holdAfterEnd", cpuHold, 0);
    endtask

    task automatic doLoad(input logic [IW-1:0] d);
        logic [15:0] frame;
        frame = {3'($urandom_range(0, 7)), d, 1'($urandom_range(0, 1))};
        sendCmd(mkCmd(4'h2));
        for (int i = 0; i < 16; i++) sendBit(frame[i]);
        mLatch = d;
        check("latchAfterLoad", memWData, mLatch);
    endtask

    task automatic doInc();
        sendCmd(mkCmd(4'h6));
        mAddr = mAddr + 1'b1;
        check("addrAfterInc", memAddr, mAddr);
    endtask

    task automatic doProg();
        expQ.push_back({mAddr, mLatch});
        refMem[mAddr] = mLatch;
        sendCmd(mkCmd(4'h8));
        waitClks(2);
        check("writeDone", expQ.size(), 0);
    endtask

    task automatic doRead();
        logic [15:0] rx, oe, expFrame;
        sendCmd(mkCmd(4'h4));
        expFrame = {3'b000, refMem[mAddr], 1'b0};
        for (int i = 0; i < 16; i++) begin
            pgmDataIn = 1'($urandom_range(0, 1));
            waitClks(4);
            pgmClk = 1'b1;
            waitClks(4);
            rx[i] = pgmDataOut;
            oe[i] = pgmDataOe;
            pgmClk = 1'b0;
        end
        waitClks(6);
        check("readFrame", rx, expFrame);
        check("readOeFrame", oe, 16'hFFFF);
        check("readOeDropped", pgmDataOe, 0);
    endtask

    task automatic doUnknown(input logic [5:0] c);
        sendCmd(c);
        waitClks(2);
        check("addrAfterUnknown", memAddr, mAddr);
        check("noOeAfterUnknown", pgmDataOe, 0);
    endtask

    function automatic logic [5:0] randUnknown();
        logic [3:0] op;
        do op = 4'($urandom_range(0, 15));
        while (op == 4'h2 || op == 4'h4 || op == 4'h6 || op == 4'h8);
        return mkCmd(op);
    endfunction

    initial begin
        #3_000_000;
        check("watchdogTimeout", runDone, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [IW-1:0] v;
        for (int i = 0; i < 512; i++) begin
            v = IW'($urandom);
            physMem[i] = v;
            refMem[i]  = v;
        end
        rst_n = 1'b0; pgmEn = 1'b0; pgmClk = 1'b0; pgmDataIn = 1'b0;
        mAddr = '0; mLatch = '0;
        waitClks(3);
        check("resetOutputs", {cpuHold, memWe, busy, pgmDataOe, pgmDataOut, memAddr, memWData}, 0);
        rst_n = 1'b1;
        waitClks(8);
        check("holdIdleAfterReset", cpuHold, 0);

        // Single word program
        startSession();
        doLoad(12'hA5C);
        check("specWord", memWData, 12'hA5C);
        doProg();
        endSession();

        // Read-back of address 3
        startSession();
        repeat (3) doInc();
        doLoad(12'h7E1);
        doProg();
        endSession();
        startSession();
        repeat (3) doInc();
        doRead();

        // Unknown command, then normal load/program/read
        doUnknown(6'h3F);
        doLoad(IW'($urandom));
        doProg();
        doRead();
        endSession();

        // Address wrap
        startSession();
        repeat (512) doInc();
        check("addrWrapped", memAddr, 9'd0);
        endSession();

        // Reset mid-load clears latch and address
        startSession();
        doInc();
        sendCmd(mkCmd(4'h2));
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        rst_n = 1'b0; pgmEn = 1'b0; pgmClk = 1'b0;
        mAddr = '0; mLatch = '0;
        waitClks(2);
        check("midResetOutputs", {cpuHold, memWe, busy, pgmDataOe, pgmDataOut, memAddr, memWData}, 0);
        rst_n = 1'b1;
        waitClks(8);
        check("holdAfterMidReset", cpuHold, 0);

        // Abort after 8 frame bits
        startSession();
        sendCmd(mkCmd(4'h2));
        for (int i = 0; i < 8; i++) sendBit(1'($urandom_range(0, 1)));
        pgmEn = 1'b0;
        waitClks(3);
        check("holdBeforeRelease", cpuHold, 1);
        waitClks(1);
        check("holdReleased", cpuHold, 0);
        check("latchAfterAbort", memWData, mLatch);
        waitClks(4);
        startSession();
        doProg();
        doRead();
        endSession();

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            startSession();
            for (int k = 0; k < 10; k++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: doInc();
                    4, 5:       doLoad(IW'($urandom));
                    6:          doProg();
                    7, 8:       doRead();
                    default:    doUnknown(randUnknown());
                endcase
            end
            endSession();
        end

        check("noPendingWrites", expQ.size(), 0);
        runDone = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
